pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PCAsrc  input  1  adder A select from branch-condition stage: 0 = constant 4, 1 = imm.
REQ-005 SHALL have port PCBsrc  input  1  adder B select from branch-condition stage: 0 = current pc, 1 = rs1.
REQ-006 SHALL have port imm  input  32  immediate of the instruction in execute.
REQ-007 SHALL have port rs1  input  32  register rs1 value of the instruction in execute.
REQ-008 SHALL have port commit_valid  input  1  execute stage has finished the current instruction; PCAsrc/PCBsrc/imm/rs1 are valid.
REQ-009 SHALL have port commit_ready  output  1  pc_gen accepts a commit this cycle.
REQ-010 SHALL have port fetch_valid  output  1  pc holds an address to be fetched.
REQ-011 SHALL have port fetch_ready  input  1  fetch unit accepts pc.
REQ-012 SHALL have port pc  output  32  current program counter.
REQ-013 SHALL have port misalign  output  1  sticky flag: computed target not 4-byte aligned.
REQ-014 SHALL have port instret  output  64  count of committed instructions.

Function
REQ-015 SHALL implement FSM states S_FETCH, S_EXEC, S_TRAP.
REQ-016 In S_FETCH: fetch_valid=1, commit_ready=0; on fetch_valid&fetch_ready, go to S_EXEC next edge; otherwise hold; pc held stable.
REQ-017 In S_EXEC: fetch_valid=0, commit_ready=1; commit_valid low holds state and pc.
REQ-018 Target SHALL be computed as (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc), 32-bit, carry discarded (wrap at 2^32).
REQ-019 When PCBsrc=1, bit 0 of target SHALL be forced to 0 (JALR rule) before alignment check.
REQ-020 On commit (S_EXEC & commit_valid) with target[1:0]==0: pc<=target, instret<=instret+1, state<=S_FETCH; fetch_valid high the cycle after commit.
REQ-021 On commit with target[1:0]!=0: pc unchanged, instret<=instret+1, misalign<=1, state<=S_TRAP.
REQ-022 In S_TRAP: fetch_valid=0, commit_ready=0; all inputs ignored; exit only by reset.
REQ-023 commit_valid in S_FETCH/S_TRAP and fetch_ready in S_EXEC/S_TRAP SHALL be ignored.
REQ-024 instret SHALL wrap from all-ones to 0 without side effect.
REQ-025 Outputs fetch_valid, commit_ready, misalign SHALL be decoded from registered state only (no input-to-output combinational path).

Reset
REQ-026 On rst asserted, immediately: pc=RESET_PC, state=S_FETCH, misalign=0, instret=0; fetch_valid=1 while in reset.
REQ-027 Reset mid-handshake (any state) SHALL abandon the in-flight instruction; first fetch after release presents RESET_PC.

Structure
REQ-028 Shared package SHALL hold the FSM state enum (2-bit encoding) and RESET_PC default constant.
REQ-029 Target adder and JALR/alignment logic SHALL be one sub-module pc_target_calc (combinational); pc_gen holds FSM, pc register and counter.

Verification
REQ-030 Reset release, fetch_ready=1, then commit with PCAsrc=0,PCBsrc=0 -> pc 8000_0000 then 8000_0004, instret=1.
REQ-031 pc=8000_0010, commit PCAsrc=1,PCBsrc=0, imm=FFFF_FFF0 -> pc=8000_0000 (backward branch).
REQ-032 commit PCAsrc=1,PCBsrc=1, rs1=8000_0101, imm=3 -> target 8000_0104 after bit0 clear, no trap; rs1=8000_0102, imm=0 -> misalign=1, S_TRAP, pc unchanged, fetch_valid=0.
REQ-033 fetch_ready held 0 for 5 cycles -> fetch_valid stays 1, pc stable; commit_valid pulses during that window ignored, instret unchanged.
REQ-034 pc=FFFF_FFFC, sequential commit -> pc=0000_0000 (wrap); rst asserted in S_EXEC -> pc=8000_0000 same cycle, instret=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator and its
// target calculator.
package pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] SEQ_STEP         = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } pc_state_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Next-pc target adder: (imm or 4) + (rs1 or pc), with the JALR bit-0 clear
// applied before the 4-byte alignment check.
module pc_target_calc
  import pc_gen_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  output logic [31:0] target,
  output logic        target_misaligned
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;

  always_comb begin
    op_a = PCAsrc ? imm : SEQ_STEP;
    op_b = PCBsrc ? rs1 : pc;
    // 32-bit add; the carry out is dropped so the address wraps at 2^32.
    sum  = op_a + op_b;
    target = sum;
    if (PCBsrc) begin
      target[0] = 1'b0;
    end
    target_misaligned = !word_aligned(target);
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch/execute/trap sequencing, pc register and
// retired-instruction counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid/ready are decoded from registered state only, so neither
// side sees a combinational path from its own inputs.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        commit_valid,
  output logic        commit_ready,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        misalign,
  output logic [63:0] instret,
  output pc_state_t   state_dbg
);

  pc_state_t   state;
  logic [31:0] target;
  logic        target_misaligned;
  logic        fetch_fire;
  logic        commit_fire;

  pc_target_calc u_target (
    .pc                (pc),
    .imm               (imm),
    .rs1               (rs1),
    .PCAsrc            (PCAsrc),
    .PCBsrc            (PCBsrc),
    .target            (target),
    .target_misaligned (target_misaligned)
  );

  assign fetch_valid  = (state == S_FETCH);
  assign commit_ready = (state == S_EXEC);
  assign state_dbg    = state;

  assign fetch_fire  = fetch_valid && fetch_ready;
  assign commit_fire = commit_ready && commit_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      misalign <= 1'b0;
      instret  <= 64'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_fire) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit_fire) begin
            instret <= instret + 64'd1;
            if (target_misaligned) begin
              // The faulting instruction still retires; pc keeps its address.
              misalign <= 1'b1;
              state    <= S_TRAP;
            end else begin
              pc    <= target;
              state <= S_FETCH;
            end
          end
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: sequential, branch, JALR, stall,
// wrap, trap and reset scenarios with hand-computed expectations.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk;
  logic        rst;
  logic        PCAsrc;
  logic        PCBsrc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        commit_valid;
  logic        commit_ready;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        misalign;
  logic [63:0] instret;
  pc_state_t   state_dbg;

  int errors = 0;
  int checks = 0;

  pc_gen #(.RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCAsrc       (PCAsrc),
    .PCBsrc       (PCBsrc),
    .imm          (imm),
    .rs1          (rs1),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .pc           (pc),
    .misalign     (misalign),
    .instret      (instret),
    .state_dbg    (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present pc to fetch and complete the handshake; lands in S_EXEC.
  task automatic do_fetch(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_fv"}, {63'd0, fetch_valid}, 64'd1);
    chk({tag, "_pc"}, {32'd0, pc}, {32'd0, exp_pc});
    fetch_ready = 1'b1;
    next_cycle();
    fetch_ready = 1'b0;
    chk({tag, "_cr"}, {63'd0, commit_ready}, 64'd1);
  endtask

  task automatic do_commit(input logic a, input logic b, input logic [31:0] i, input logic [31:0] r);
    PCAsrc = a;
    PCBsrc = b;
    imm = i;
    rs1 = r;
    commit_valid = 1'b1;
    next_cycle();
    commit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    PCAsrc = 1'b0;
    PCBsrc = 1'b0;
    imm = 32'd0;
    rs1 = 32'd0;
    commit_valid = 1'b0;
    fetch_ready = 1'b0;
    #12;
    chk("rst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("rst_fv", {63'd0, fetch_valid}, 64'd1);
    chk("rst_cr", {63'd0, commit_ready}, 64'd0);
    chk("rst_mis", {63'd0, misalign}, 64'd0);
    chk("rst_ir", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // sequential step
    do_fetch("seq_f", 32'h8000_0000);
    do_commit(1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
    chk("seq_pc", {32'd0, pc}, 64'h8000_0004);
    chk("seq_ir", instret, 64'd1);
    chk("seq_fv", {63'd0, fetch_valid}, 64'd1);

    // forward then backward branch
    do_fetch("fwd_f", 32'h8000_0004);
    do_commit(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    chk("fwd_pc", {32'd0, pc}, 64'h8000_0010);
    do_fetch("bwd_f", 32'h8000_0010);
    do_commit(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("bwd_pc", {32'd0, pc}, 64'h8000_0000);
    chk("bwd_ir", instret, 64'd3);

    // JALR with bit-0 clear stays aligned
    do_fetch("jalr_f", 32'h8000_0000);
    do_commit(1'b1, 1'b1, 32'h0000_0003, 32'h8000_0101);
    chk("jalr_pc", {32'd0, pc}, 64'h8000_0104);
    chk("jalr_mis", {63'd0, misalign}, 64'd0);
    chk("jalr_ir", instret, 64'd4);

    // fetch stall with stray commit_valid pulses
    for (int i = 0; i < 5; i++) begin
      commit_valid = i[0];
      next_cycle();
      chk("stall_fv", {63'd0, fetch_valid}, 64'd1);
      chk("stall_pc", {32'd0, pc}, 64'h8000_0104);
      chk("stall_ir", instret, 64'd4);
    end
    commit_valid = 1'b0;

    // exec hold with stray fetch_ready
    do_fetch("hold_f", 32'h8000_0104);
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("hold_cr", {63'd0, commit_ready}, 64'd1);
      chk("hold_pc", {32'd0, pc}, 64'h8000_0104);
    end
    fetch_ready = 1'b0;
    do_commit(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
    chk("top_pc", {32'd0, pc}, 64'hFFFF_FFFC);

    // sequential wrap past 2^32
    do_fetch("wrap_f", 32'hFFFF_FFFC);
    do_commit(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", {32'd0, pc}, 64'h0000_0000);
    chk("wrap_ir", instret, 64'd6);

    // misaligned JALR -> trap
    do_fetch("trap_f", 32'h0000_0000);
    do_commit(1'b1, 1'b1, 32'h0, 32'h8000_0102);
    chk("trap_mis", {63'd0, misalign}, 64'd1);
    chk("trap_pc", {32'd0, pc}, 64'h0000_0000);
    chk("trap_fv", {63'd0, fetch_valid}, 64'd0);
    chk("trap_cr", {63'd0, commit_ready}, 64'd0);
    chk("trap_ir", instret, 64'd7);
    chk("trap_st", {62'd0, state_dbg}, {62'd0, S_TRAP});
    fetch_ready = 1'b1;
    commit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("trap_hold_st", {62'd0, state_dbg}, {62'd0, S_TRAP});
      chk("trap_hold_ir", instret, 64'd7);
    end
    fetch_ready = 1'b0;
    commit_valid = 1'b0;

    // reset leaves trap immediately
    rst = 1'b1;
    #1;
    chk("trst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("trst_mis", {63'd0, misalign}, 64'd0);
    chk("trst_ir", instret, 64'd0);
    chk("trst_fv", {63'd0, fetch_valid}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // reset mid-exec abandons the instruction
    do_fetch("r2_f", 32'h8000_0000);
    do_commit(1'b0, 1'b0, 32'h0, 32'h0);
    chk("r2_ir", instret, 64'd1);
    do_fetch("r3_f", 32'h8000_0004);
    commit_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("xrst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("xrst_ir", instret, 64'd0);
    chk("xrst_fv", {63'd0, fetch_valid}, 64'd1);
    commit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    do_fetch("post_f", 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
